// File: rtl/gray_ptr_rx_if.sv
// Pointer-crossing bundle between the far-domain Gray pointer source and the read-side receiver.
// The master drives gray_in/local_bin; the receiver (slave) returns the decoded pointer and status.
interface gray_ptr_rx_if #(
    parameter int PTR_W = 4
);
    logic [PTR_W-1:0] gray_in;
    logic [PTR_W-1:0] local_bin;
    logic [PTR_W-1:0] bin_out;
    logic             ptr_adv;
    logic [PTR_W-1:0] count;
    logic             empty;
    logic             gray_err;

    modport master (
        output gray_in, local_bin,
        input  bin_out, ptr_adv, count, empty, gray_err
    );

    modport slave (
        input  gray_in, local_bin,
        output bin_out, ptr_adv, count, empty, gray_err
    );
endinterface

// File: rtl/gray_ptr_rx.sv
// Read-side receiver for a Gray-coded FIFO pointer: synchronizer, prime/accept logic, decode, count/empty.
// Optional macro GRAY_CHK_EN rejects multi-bit Gray steps and raises a sticky gray_err.
//
// state   | meaning
// S_FILL  | synchronizer still filling after reset; sync output not yet valid
// S_PRIME | next valid sample is the prime sample, accepted unconditionally
// S_RUN   | normal operation; each valid sample may advance the pointer
module gray_ptr_rx #(
    parameter int DEPTH       = 8,
    parameter int PTR_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    gray_ptr_rx_if.slave   bus
);
    localparam int CNT_W = $clog2(SYNC_STAGES + 1);

    if (PTR_W != $clog2(DEPTH) + 1) begin : g_bad_ptr_w
        $error("gray_ptr_rx: PTR_W must equal clog2(DEPTH)+1");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("gray_ptr_rx: SYNC_STAGES must be 2 or 3");
    end

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_nxt;
    logic [PTR_W-1:0] sync_q [1:SYNC_STAGES];
    logic [PTR_W-1:0] acc_gray_q, acc_gray_nxt;
    logic [PTR_W-1:0] bin_q, bin_nxt;
    logic             adv_q, adv_nxt;
    logic [PTR_W-1:0] sample;
    logic [PTR_W-1:0] dec_bin;
    logic             take;
`ifdef GRAY_CHK_EN
    logic [PTR_W-1:0] step_diff;
    logic             multi_step;
    logic             err_set;
    logic             err_q;
`endif

    assign sample = sync_q[SYNC_STAGES];

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        dec_bin = '0;
        for (int i = 0; i < PTR_W; i++) begin
            dec_bin[i] = ^(sample >> i);
        end
    end

`ifdef GRAY_CHK_EN
    assign step_diff  = sample ^ acc_gray_q;
    assign multi_step = (step_diff & (step_diff - PTR_W'(1))) != '0;
`endif

    always_comb begin
        state_nxt    = state_q;
        fill_cnt_nxt = fill_cnt_q;
        acc_gray_nxt = acc_gray_q;
        bin_nxt      = bin_q;
        adv_nxt      = 1'b0;
        take         = 1'b0;
`ifdef GRAY_CHK_EN
        err_set      = 1'b0;
`endif
        case (state_q)
            S_FILL: begin
                fill_cnt_nxt = fill_cnt_q + 1'b1;
                if (fill_cnt_q == CNT_W'(SYNC_STAGES - 1)) begin
                    state_nxt = S_PRIME;
                end
            end
            S_PRIME: begin
                state_nxt = S_RUN;
                take      = (sample != acc_gray_q);
            end
            S_RUN: begin
`ifdef GRAY_CHK_EN
                if (sample != acc_gray_q) begin
                    if (multi_step) begin
                        err_set = 1'b1;
                    end else begin
                        take = 1'b1;
                    end
                end
`else
                take = (sample != acc_gray_q);
`endif
            end
            default: state_nxt = S_FILL;
        endcase
        if (take) begin
            acc_gray_nxt = sample;
            bin_nxt      = dec_bin;
            adv_nxt      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FILL;
            fill_cnt_q <= '0;
            for (int i = 1; i <= SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            acc_gray_q <= '0;
            bin_q      <= '0;
            adv_q      <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            fill_cnt_q <= fill_cnt_nxt;
            sync_q[1]  <= bus.gray_in;
            for (int i = 2; i <= SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            acc_gray_q <= acc_gray_nxt;
            bin_q      <= bin_nxt;
            adv_q      <= adv_nxt;
        end
    end

`ifdef GRAY_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end
    assign bus.gray_err = err_q;
`else
    assign bus.gray_err = 1'b0;
`endif

    assign bus.bin_out = bin_q;
    assign bus.ptr_adv = adv_q;
    // Modular subtraction absorbs wrap across the extra pointer bit.
    assign bus.count   = bin_q - bus.local_bin;
    assign bus.empty   = (bus.count == '0);
endmodule

// File: tb/tb_gray_ptr_rx.sv
// Directed bench for gray_ptr_rx (DEPTH=8, PTR_W=4, SYNC_STAGES=2); expectations follow GRAY_CHK_EN.
module tb_gray_ptr_rx;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    gray_ptr_rx_if #(.PTR_W(4)) bus ();

    gray_ptr_rx #(
        .DEPTH(8),
        .PTR_W(4),
        .SYNC_STAGES(2)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a new Gray value, expect it on bin_out three edges later with a single ptr_adv pulse.
    task automatic apply(input string tag, input logic [3:0] g, input logic [3:0] exp_bin,
                         input logic [3:0] exp_count, input logic exp_empty);
        bus.gray_in = g;
        step(2);
        chk({tag, "_adv_early"}, bus.ptr_adv, 1'b0);
        step(1);
        chk({tag, "_bin"},   bus.bin_out, exp_bin);
        chk({tag, "_adv"},   bus.ptr_adv, 1'b1);
        chk({tag, "_count"}, bus.count,   exp_count);
        chk({tag, "_empty"}, bus.empty,   exp_empty);
        step(1);
        chk({tag, "_adv_drop"}, bus.ptr_adv, 1'b0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.gray_in   = 4'b0000;
        bus.local_bin = 4'd0;

        // Reset state
        step(2);
        chk("rst_bin",   bus.bin_out,  4'd0);
        chk("rst_count", bus.count,    4'd0);
        chk("rst_empty", bus.empty,    1'b1);
        chk("rst_adv",   bus.ptr_adv,  1'b0);
        chk("rst_err",   bus.gray_err, 1'b0);
        rst = 1'b0;
        step(3);
        chk("prime_zero_adv", bus.ptr_adv, 1'b0);
        chk("prime_zero_bin", bus.bin_out, 4'd0);

        // Single-step advance
        apply("s1", 4'b0001, 4'd1, 4'd1, 1'b0);
        apply("s2", 4'b0011, 4'd2, 4'd2, 1'b0);
        apply("s3", 4'b0010, 4'd3, 4'd3, 1'b0);
        bus.local_bin = 4'd1;
        #1;
        chk("count_comb", bus.count, 4'd2);
        bus.local_bin = 4'd3;
        #1;
        chk("empty_comb", bus.empty, 1'b1);

        // Wrap across the extra bit, primed straight to 14 after a reset
        rst           = 1'b1;
        bus.gray_in   = 4'b1001;
        bus.local_bin = 4'd14;
        step(1);
        chk("wrap_rst_count", bus.count, 4'd2);
        chk("wrap_rst_empty", bus.empty, 1'b0);
        rst = 1'b0;
        step(2);
        chk("wrap_hold_bin", bus.bin_out, 4'd0);
        step(1);
        chk("wrap_prime_bin",   bus.bin_out, 4'd14);
        chk("wrap_prime_adv",   bus.ptr_adv, 1'b1);
        chk("wrap_prime_count", bus.count,   4'd0);
        chk("wrap_prime_empty", bus.empty,   1'b1);
        step(1);
        apply("w15", 4'b1000, 4'd15, 4'd1, 1'b0);
        apply("w0",  4'b0000, 4'd0,  4'd2, 1'b0);

        // Illegal two-bit jump 0000 -> 0011
        bus.local_bin = 4'd0;
        bus.gray_in   = 4'b0011;
        step(3);
`ifdef GRAY_CHK_EN
        chk("jump_bin", bus.bin_out,  4'd0);
        chk("jump_adv", bus.ptr_adv,  1'b0);
        chk("jump_err", bus.gray_err, 1'b1);
`else
        chk("jump_bin", bus.bin_out,  4'd2);
        chk("jump_adv", bus.ptr_adv,  1'b1);
        chk("jump_err", bus.gray_err, 1'b0);
`endif
        step(1);
        chk("jump_adv_after", bus.ptr_adv, 1'b0);
        // 0001 is one bit from both 0000 and 0011, so either build accepts it
        bus.gray_in = 4'b0001;
        step(3);
        chk("post_jump_bin", bus.bin_out, 4'd1);
        chk("post_jump_adv", bus.ptr_adv, 1'b1);
`ifdef GRAY_CHK_EN
        chk("err_sticky", bus.gray_err, 1'b1);
`else
        chk("err_tied", bus.gray_err, 1'b0);
`endif

        // Reset mid-run; prime sample 0110 is exempt from the step check
        bus.gray_in = 4'b0110;
        rst         = 1'b1;
        step(1);
        chk("mid_rst_bin", bus.bin_out,  4'd0);
        chk("mid_rst_err", bus.gray_err, 1'b0);
        chk("mid_rst_adv", bus.ptr_adv,  1'b0);
        rst = 1'b0;
        step(1);
        chk("mid_fill1_bin", bus.bin_out, 4'd0);
        step(1);
        chk("mid_fill2_bin", bus.bin_out, 4'd0);
        chk("mid_fill2_adv", bus.ptr_adv, 1'b0);
        step(1);
        chk("mid_prime_bin",   bus.bin_out,  4'd4);
        chk("mid_prime_adv",   bus.ptr_adv,  1'b1);
        chk("mid_prime_err",   bus.gray_err, 1'b0);
        chk("mid_prime_count", bus.count,    4'd4);
        step(1);
        chk("mid_adv_drop", bus.ptr_adv, 1'b0);
        chk("mid_bin_hold", bus.bin_out, 4'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gray_ptr_rx.md
# gray_ptr_rx

Receive side of the FIFO's Gray-coded pointer crossing. The block takes a Gray-coded pointer launched from the far clock domain and passes it through a multi-flop synchronizer. It decodes the result back to binary, registers it, and derives the occupancy count and empty flag against the local binary pointer. It sits on the read side of the async FIFO, opposite the write-side binary-to-Gray encoder.

## Interface
- DEPTH, 8, FIFO depth in entries; power of two.
- PTR_W, 4, pointer width; must equal clog2(DEPTH)+1 (extra wrap bit).
- SYNC_STAGES, 2, synchronizer flop count; legal values 2 or 3.

- clk  in  1  local (read-side) clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- gray_in  in  PTR_W  remote pointer, Gray-coded, asynchronous to clk.
- local_bin  in  PTR_W  local pointer, binary, synchronous to clk.
- bin_out  out  PTR_W  decoded, registered remote pointer.
- ptr_adv  out  1  one-cycle pulse, coincident with bin_out taking a new value.
- count  out  PTR_W  (bin_out − local_bin) mod 2^PTR_W.
- empty  out  1  high when count == 0.
- gray_err  out  1  sticky flag for an illegal multi-bit Gray step.

## Operation
- Synchronizer: gray_in → sync[1] → … → sync[SYNC_STAGES], one flop per edge. No logic between stages.
- Fill counter: counts 0..SYNC_STAGES after reset and saturates there.
  - The sample in sync[SYNC_STAGES] is valid only once the counter has saturated.
  - The first valid sample after reset is the prime sample. It is accepted unconditionally.
- Decode, combinational from sync[SYNC_STAGES]:
  - bin[PTR_W−1] = g[PTR_W−1]
  - bin[i] = bin[i+1] ^ g[i], for i = PTR_W−2 down to 0.
- Accept register: holds the last accepted Gray value (acc_gray) and its decode (bin_out).
  - On each valid sample, if the sample is accepted and differs from acc_gray, both are updated and ptr_adv is pulsed.
  - If the sample equals acc_gray, both hold and ptr_adv stays 0.
- count and empty: combinational from bin_out and local_bin.
  - Subtraction is PTR_W-bit modular, so it handles wrap-around across the extra bit with no special case.
- Wrap: Gray 1000 → 0000 (binary 15 → 0) is a legal single-bit step and decodes normally.
- Reset values, at the first edge with rst high:
  - sync[*], acc_gray, bin_out, fill counter, ptr_adv, gray_err all = 0.
  - Hence count = (0 − local_bin) mod 2^PTR_W.
- Reset mid-operation: all state is cleared at that edge. The fill counter restarts, and the next valid sample is treated as a new prime sample.

## Timing
- Latency: gray_in stable before edge k → bin_out updated at edge k+SYNC_STAGES, with ptr_adv high for that one cycle.
  - For example, 3 edges end-to-end when SYNC_STAGES = 2 (2 synchronizer flops plus the output register).
- count and empty: zero-cycle from local_bin; they follow bin_out in the same cycle bin_out updates.
- ptr_adv: never high for two consecutive cycles unless bin_out changes on both.
- Throughput: one accepted pointer step per clk cycle.

## Configuration
- GRAY_CHK_EN defined:
  - Each valid non-prime sample is compared to acc_gray.
  - If popcount(sample ^ acc_gray) > 1, the sample is rejected: bin_out and acc_gray hold, ptr_adv stays 0, and gray_err is set at that edge.
  - gray_err remains set until rst.
- GRAY_CHK_EN undefined:
  - Every valid sample is accepted regardless of Hamming distance.
  - gray_err is tied to 0 and no compare logic is present.

## Test plan
- Reset with gray_in=0000, local_bin=0000 → bin_out=0, count=0, empty=1, ptr_adv=0, gray_err=0.
- Single-step advance, SYNC_STAGES=2, local_bin=0. Step gray_in 0001 → 0011 → 0010, holding each value 4 cycles.
  - Each step appears on bin_out 3 edges later: bin_out = 1, 2, 3 with one ptr_adv pulse per step.
  - count = 1, 2, 3; empty=0.
- Wrap, local_bin=14 (1110). Step gray_in 1001 → 1000 → 0000.
  - bin_out = 14, 15, 0; count = 0, 1, 2; empty goes 1, 0, 0.
- Illegal jump: gray_in 0000 → 0011 after prime.
  - With GRAY_CHK_EN: gray_err=1, bin_out stays 0, no ptr_adv.
  - Without GRAY_CHK_EN: bin_out=2, ptr_adv pulse, gray_err=0.
- Reset mid-run with gray_in held at 0110.
  - bin_out=0 while rst is high and for SYNC_STAGES cycles after release.
  - bin_out then becomes 4 with a ptr_adv pulse and gray_err=0, because the prime sample is exempt from the check.
